// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: fixed-period counter, boundary-sampled signed duty command, dead-band leg sequencing.
// Build option: define MOTOR_PWM_DEADTIME_EN to insert DT_HI/DT_LO dead-band states; otherwise legs switch directly.
module motor_pwm_driver #(
    parameter int PERIOD   = 2500,
    parameter int DEADTIME = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_in,
    input  logic        enable,
    output logic        pwm_hi,
    output logic        pwm_lo,
    output logic        dir,
    output logic        period_start,
    output logic [15:0] duty_out
);

    localparam logic [15:0] CNT_LAST   = 16'(PERIOD - 1);
    localparam logic [15:0] DUTY_MAX   = 16'(PERIOD);
    localparam logic [32:0] PERIOD_EXT = 33'(PERIOD);

    if (PERIOD < 2 || PERIOD > 65535 || DEADTIME < 1 || DEADTIME > 255 || 2 * DEADTIME >= PERIOD) begin : g_bad_params
        $error("motor_pwm_driver: PERIOD/DEADTIME out of range");
    end

    logic [15:0] cnt;
    logic [15:0] duty_q;
    logic [32:0] cmd_mag;
    logic [15:0] duty_nx;
    logic        dmd;

    // 33-bit magnitude so that -2^31 negates without overflow
    assign cmd_mag  = cmd_in[31] ? (33'd0 - {cmd_in[31], cmd_in}) : {1'b0, cmd_in};
    assign duty_nx  = (cmd_mag > PERIOD_EXT) ? DUTY_MAX : cmd_mag[15:0];
    assign dmd      = enable && (cnt < duty_q);
    assign duty_out = duty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            duty_q       <= '0;
            dir          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) begin
                cnt    <= '0;
                duty_q <= duty_nx;
                dir    <= cmd_in[31];
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

`ifdef MOTOR_PWM_DEADTIME_EN
    // state  | meaning
    // OFF    | bridge disabled, both legs off
    // HI     | high-side leg on
    // LO     | low-side leg on
    // DT_HI  | dead band, both off, heading to HI
    // DT_LO  | dead band, both off, heading to LO
    typedef enum logic [2:0] {OFF, HI, LO, DT_HI, DT_LO} state_t;

    localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);

    state_t     state;
    logic [7:0] dt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (!enable) begin
            state  <= OFF;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state  <= dmd ? DT_HI : DT_LO;
                    dt_cnt <= DT_LOAD;
                end
                HI: if (!dmd) begin
                    state  <= DT_LO;
                    dt_cnt <= DT_LOAD;
                    pwm_hi <= 1'b0;
                end
                LO: if (dmd) begin
                    state  <= DT_HI;
                    dt_cnt <= DT_LOAD;
                    pwm_lo <= 1'b0;
                end
                DT_HI: begin
                    if (!dmd) begin
                        state  <= DT_LO;
                        dt_cnt <= DT_LOAD;
                    end else if (dt_cnt == 8'd0) begin
                        state  <= HI;
                        pwm_hi <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - 8'd1;
                    end
                end
                DT_LO: begin
                    if (dmd) begin
                        state  <= DT_HI;
                        dt_cnt <= DT_LOAD;
                    end else if (dt_cnt == 8'd0) begin
                        state  <= LO;
                        pwm_lo <= 1'b1;
                    end else begin
                        dt_cnt <= dt_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= OFF;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end
`else
    // state  | meaning
    // OFF    | bridge disabled, both legs off
    // HI     | high-side leg on
    // LO     | low-side leg on
    typedef enum logic [1:0] {OFF, HI, LO} state_t;

    state_t state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= OFF;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (!enable) begin
            state  <= OFF;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (dmd) begin
            state  <= HI;
            pwm_hi <= 1'b1;
            pwm_lo <= 1'b0;
        end else begin
            state  <= LO;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized bench for motor_pwm_driver against a run-length reference model of the leg outputs.
// Follows the MOTOR_PWM_DEADTIME_EN build option of the design.
module tb_motor_pwm_driver;

    localparam int P  = 100;
    localparam int DT = 4;
`ifdef MOTOR_PWM_DEADTIME_EN
    localparam int TH     = DT + 1;
    localparam int EXP_HI = 30 - DT;
    localparam int EXP_LO = 70 - DT;
`else
    localparam int TH     = 1;
    localparam int EXP_HI = 30;
    localparam int EXP_LO = 70;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmd_in = '0;
    logic        enable = 1'b0;
    logic        pwm_hi, pwm_lo, dir, period_start;
    logic [15:0] duty_out;

    int checks = 0;
    int errors = 0;

    int m_cnt, m_duty, hi_run, lo_run;
    bit m_dir, m_hi, m_lo, m_ps;
    int hi_acc, lo_acc;
    bit counting;

    always #5 clk = ~clk;

    motor_pwm_driver #(.PERIOD(P), .DEADTIME(DT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_in       (cmd_in),
        .enable       (enable),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .dir          (dir),
        .period_start (period_start),
        .duty_out     (duty_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_mag(input int cmd);
        longint m;
        m = cmd;
        if (m < 0) m = -m;
        if (m > P) m = P;
        return int'(m);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_dir = 0;
        m_hi = 0; m_lo = 0; m_ps = 0;
        hi_run = 0; lo_run = 0;
    endtask

    // A leg is on once its demand has held for the dead band plus one registration cycle
    task automatic model_step(input bit en, input int cmd);
        bit d, l;
        d = en && (m_cnt < m_duty);
        l = en && !d;
        hi_run = d ? hi_run + 1 : 0;
        lo_run = l ? lo_run + 1 : 0;
        m_hi = (hi_run >= TH);
        m_lo = (lo_run >= TH);
        m_ps = (m_cnt == P - 1);
        if (m_cnt == P - 1) begin
            m_cnt  = 0;
            m_duty = sat_mag(cmd);
            m_dir  = (cmd < 0);
        end else begin
            m_cnt++;
        end
    endtask

    task automatic run_cycle(input bit en, input int cmd);
        @(negedge clk);
        chk("pwm_hi", 32'(pwm_hi), 32'(m_hi));
        chk("pwm_lo", 32'(pwm_lo), 32'(m_lo));
        chk("overlap", 32'(pwm_hi & pwm_lo), 32'd0);
        chk("dir", 32'(dir), 32'(m_dir));
        chk("period_start", 32'(period_start), 32'(m_ps));
        chk("duty_out", 32'(duty_out), 32'(m_duty));
        if (counting) begin
            hi_acc += int'(pwm_hi);
            lo_acc += int'(pwm_lo);
        end
        enable = en;
        cmd_in = cmd;
        model_step(en, cmd);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic int pick_cmd();
        int v;
        case ($urandom_range(0, 7))
            0: v = 0;
            1: v = 30;
            2: v = -250;
            3: v = 32'h8000_0000;
            4: v = P;
            5: v = -P;
            6: begin
                v = int'($urandom_range(0, 120));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = int'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        bit en_r;
        int cmd_r;
        model_reset();
        counting = 0;
        hi_acc = 0;
        lo_acc = 0;
        enable = 1'b1;
        cmd_in = 32'd30;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hi", 32'(pwm_hi), 32'd0);
            chk("rst_lo", 32'(pwm_lo), 32'd0);
            chk("rst_ps", 32'(period_start), 32'd0);
            chk("rst_dir", 32'(dir), 32'd0);
            chk("rst_duty", 32'(duty_out), 32'd0);
        end
        release_reset();

        // steady +30 command: measure leg on-times over the third period
        for (int i = 0; i < 3 * P; i++) begin
            counting = (i >= 2 * P);
            run_cycle(1'b1, 30);
        end
        counting = 0;
        chk("hi_time_30", 32'(hi_acc), 32'(EXP_HI));
        chk("lo_time_30", 32'(lo_acc), 32'(EXP_LO));

        // mid-period command change must wait for the boundary
        for (int i = 0; i < 2 * P; i++) run_cycle(1'b1, (i >= 50) ? 70 : 30);
        for (int i = 0; i < P; i++) run_cycle(1'b1, -250);
        for (int i = 0; i < 2 * P; i++) run_cycle(1'b1, 32'h8000_0000);

        // enable drop and recovery
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 50);
        for (int i = 0; i < 2 * P; i++) run_cycle(1'b1, 50);

        // asynchronous reset while a leg is driven
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_hi", 32'(pwm_hi), 32'd0);
        chk("async_lo", 32'(pwm_lo), 32'd0);
        chk("async_duty", 32'(duty_out), 32'd0);
        chk("async_dir", 32'(dir), 32'd0);
        model_reset();
        release_reset();

        en_r = 1'b1;
        cmd_r = 30;
        for (int i = 0; i < 20000; i++) begin
            if (en_r && $urandom_range(0, 299) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 19) == 0) en_r = 1'b1;
            if ($urandom_range(0, 39) == 0) cmd_r = pick_cmd();
            run_cycle(en_r, cmd_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
